// File: rtl/input_typematic.sv
// Purpose : N_CH button lines -> synchroniser -> tick-based debounce -> press/auto-repeat
//           events latched as per-channel pending flags, cleared by an ack handshake.
// Latency : tick=1, press at raw_in -> held after SYNC_STAGES+DB_TICKS clk, pending one clk later.
// Backpressure: none; an event arriving while pending is still set raises sticky missed.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   raw_in       asynchronous button levels (1 = pressed)
//   tick         single-cycle timebase strobe; all debounce/repeat counting advances on it
//   ack          per-channel event consumed
//   held         debounced level
//   pending      event waiting for ack
//   missed       sticky: event arrived while pending and not acked
//   any_pending  OR of pending (combinational)
module input_typematic #(
  parameter int              N_CH         = 10,
  parameter int              SYNC_STAGES  = 2,
  parameter int              DB_TICKS     = 8,
  parameter int              REPEAT_DELAY = 50,
  parameter int              REPEAT_RATE  = 10,
  parameter logic [N_CH-1:0] REPEAT_MASK  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  input  logic            tick,
  input  logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] missed,
  output logic            any_pending
);

  localparam int DBW  = $clog2(DB_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_END = DBW'(DB_TICKS);
  localparam logic [RW-1:0]  RD_END = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0]  RR_END = RW'(REPEAT_RATE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DBW-1:0]         db_cnt_q;
    logic                   held_q;
    logic                   held_prev_q;
    logic                   rise;
    logic                   ev;
    logic                   pending_q;
    logic                   missed_q;

    // Synchroniser: the only reader of raw_in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: a differing level must survive DB_TICKS ticks; any return to the
    // held level restarts the count, so short glitches never reach held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q <= '0;
        held_q   <= 1'b0;
      end else if (s == held_q) begin
        db_cnt_q <= '0;
      end else if (tick) begin
        if (db_cnt_q + DBW'(1) == DB_END) begin
          held_q   <= s;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DBW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        held_prev_q <= 1'b0;
      end else begin
        held_prev_q <= held_q;
      end
    end

    // Valid for exactly the clk after held rises.
    assign rise = held_q & ~held_prev_q;

    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_t     state_q, state_d;
      logic [RW-1:0]  rcnt_q, rcnt_d;
      logic           rep_ev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // Release is checked first so a repeat due in the same clk is dropped.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_ev  = 1'b0;
        if (!held_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (rise) begin
                state_d = DELAY;
                rcnt_d  = '0;
              end
            end
            DELAY: begin
              if (tick) begin
                if (rcnt_q + RW'(1) == RD_END) begin
                  rep_ev  = 1'b1;
                  rcnt_d  = '0;
                  state_d = REPEAT;
                end else begin
                  rcnt_d = rcnt_q + RW'(1);
                end
              end
            end
            REPEAT: begin
              if (tick) begin
                if (rcnt_q + RW'(1) == RR_END) begin
                  rep_ev = 1'b1;
                  rcnt_d = '0;
                end else begin
                  rcnt_d = rcnt_q + RW'(1);
                end
              end
            end
            default: begin
              state_d = IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      assign ev = rise | rep_ev;
    end else begin : g_norep
      assign ev = rise;
    end

    // Event latch; a coinciding ack leaves pending set but clears missed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pending_q <= 1'b0;
        missed_q  <= 1'b0;
      end else if (ev) begin
        pending_q <= 1'b1;
        if (ack[i]) begin
          missed_q <= 1'b0;
        end else if (pending_q) begin
          missed_q <= 1'b1;
        end
      end else if (ack[i] && pending_q) begin
        pending_q <= 1'b0;
        missed_q  <= 1'b0;
      end
    end

    assign held[i]    = held_q;
    assign pending[i] = pending_q;
    assign missed[i]  = missed_q;
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_input_typematic.sv
// Purpose : directed checks of input_typematic (4 channels, ch0 auto-repeats).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_input_typematic;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw_in;
  logic       tick;
  logic [3:0] ack;
  logic [3:0] held;
  logic [3:0] pending;
  logic [3:0] missed;
  logic       any_pending;

  int n_chk;
  int n_pass;

  input_typematic #(
    .N_CH         (4),
    .SYNC_STAGES  (2),
    .DB_TICKS     (3),
    .REPEAT_DELAY (4),
    .REPEAT_RATE  (2),
    .REPEAT_MASK  (4'b0001)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .tick        (tick),
    .ack         (ack),
    .held        (held),
    .pending     (pending),
    .missed      (missed),
    .any_pending (any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    raw_in = '0;
    tick   = 1'b1;
    ack    = '0;

    // Reset state
    step(2);
    chk("rst_held", held, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_missed", missed, 4'b0000);
    chk("rst_anyp", any_pending, 1'b0);
    rst_n = 1'b1;
    step(2);

    // 1. Two-clk glitch on ch1 is rejected
    raw_in[1] = 1'b1;
    step(2);
    raw_in[1] = 1'b0;
    step(10);
    chk("glitch_held1", held[1], 1'b0);
    chk("glitch_pend1", pending[1], 1'b0);

    // 1. Steady press: held at edge 5, pending at edge 6
    raw_in[1] = 1'b1;
    step(4);
    chk("press_held_e4", held[1], 1'b0);
    step(1);
    chk("press_held_e5", held[1], 1'b1);
    chk("press_pend_e5", pending[1], 1'b0);
    step(1);
    chk("press_pend_e6", pending[1], 1'b1);
    chk("press_anyp_e6", any_pending, 1'b1);

    // 2. Ack clears; long hold on a non-repeat channel gives nothing more
    ack[1] = 1'b1;
    step(1);
    ack[1] = 1'b0;
    chk("ack_clear1", pending[1], 1'b0);
    step(100);
    chk("hold_pend1", pending[1], 1'b0);
    chk("hold_missed1", missed[1], 1'b0);
    chk("hold_held1", held[1], 1'b1);
    raw_in[1] = 1'b0;
    step(10);
    chk("rel_held1", held[1], 1'b0);

    // 3. Auto-repeat on ch0, acking each event the clk it appears.
    //    Release after edge 16: held drops at edge 21, events at 6,10,12,...,20.
    raw_in[0] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      ack[0] = pending[0];
      if (e == 17) raw_in[0] = 1'b0;
      step(1);
      chk($sformatf("rep_pend_e%0d", e), pending[0],
          (e == 6 || (e >= 10 && e <= 20 && (e % 2) == 0)) ? 1'b1 : 1'b0);
      if (e == 20 || e == 21) chk($sformatf("rep_held_e%0d", e), held[0], (e < 21) ? 1'b1 : 1'b0);
    end
    ack[0] = 1'b0;
    step(1);

    // 4. No acks: missed at the second event; one ack clears both
    raw_in[0] = 1'b1;
    step(6);
    chk("miss_pend_e6", pending[0], 1'b1);
    chk("miss_missed_e6", missed[0], 1'b0);
    step(3);
    chk("miss_missed_e9", missed[0], 1'b0);
    step(1);
    chk("miss_missed_e10", missed[0], 1'b1);
    ack[0] = 1'b1;
    step(1);
    ack[0] = 1'b0;
    chk("miss_ack_pend", pending[0], 1'b0);
    chk("miss_ack_missed", missed[0], 1'b0);
    step(1);
    chk("miss_pend_e12", pending[0], 1'b1);
    step(2);
    chk("miss_missed_e14", missed[0], 1'b1);
    step(1);
    ack[0] = 1'b1;            // coincides with the event landing at edge 16
    step(1);
    ack[0] = 1'b0;
    chk("coinc_pend_e16", pending[0], 1'b1);
    chk("coinc_missed_e16", missed[0], 1'b0);
    raw_in[0] = 1'b0;
    step(8);
    ack[0] = 1'b1;
    step(1);
    ack[0] = 1'b0;
    chk("miss_final_pend", pending[0], 1'b0);
    chk("miss_final_missed", missed[0], 1'b0);
    chk("miss_final_held", held[0], 1'b0);
    step(2);

    // 5. tick=0 freezes the debounce of ch2 after one tick
    raw_in[2] = 1'b1;
    step(3);
    tick = 1'b0;
    step(20);
    chk("frz_held2", held[2], 1'b0);
    tick = 1'b1;
    step(1);
    chk("frz_resume1", held[2], 1'b0);
    step(1);
    chk("frz_resume2", held[2], 1'b1);
    step(1);
    chk("frz_pend2", pending[2], 1'b1);

    // 5. ch0 and ch3 pressed together latch together
    raw_in[0] = 1'b1;
    raw_in[3] = 1'b1;
    step(5);
    chk("sim_pend_e5", pending & 4'b1001, 4'b0000);
    step(1);
    chk("sim_pend_e6", pending & 4'b1001, 4'b1001);
    step(4);
    chk("sim_missed0_e10", missed[0], 1'b1);
    step(3);

    // 6. Async reset mid-repeat, then re-press from a line still high
    rst_n  = 1'b0;
    raw_in = 4'b0001;
    #1;
    chk("arst_held", held, 4'b0000);
    chk("arst_pending", pending, 4'b0000);
    chk("arst_missed", missed, 4'b0000);
    chk("arst_anyp", any_pending, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_held_e5", held, 4'b0001);
    chk("post_rst_pend_e5", pending, 4'b0000);
    step(1);
    chk("post_rst_pend_e6", pending, 4'b0001);
    chk("post_rst_anyp_e6", any_pending, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
